pe_mac_tile: RTL

//  Next-generation systolic processing element: output-stationary MAC with per-stream valid

---
 rtl/pe_mac_tile.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pe_mac_tile.sv
// Output-stationary systolic MAC processing element.
// North operands pass south and west operands pass east, each through one register.
// A MAC fires when both streams are valid. The product flows through a three-stage
// pipeline into a saturating or wrapping accumulator. A last-tagged fire closes the
// tile: it publishes the result with a one-cycle result_vld pulse and clears the
// accumulator, so the next tile can start with no bubble.
//
// Handshake: there is no backpressure. in_*_vld qualifies its data in that cycle
// only. out_*_vld carries the same qualification one cycle later. result_vld is a
// single-cycle strobe, and result/result_ovf hold their value until the next strobe.
module pe_mac_tile #(
  parameter int DATA_BIT = 8,
  parameter int ACC_BIT  = 24,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  parameter int CNT_BIT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_BIT-1:0] in_north,
  input  logic                in_north_vld,
  input  logic [DATA_BIT-1:0] in_west,
  input  logic                in_west_vld,
  input  logic                in_west_last,
  output logic [DATA_BIT-1:0] out_south,
  output logic                out_south_vld,
  output logic [DATA_BIT-1:0] out_east,
  output logic                out_east_vld,
  output logic                out_east_last,
  output logic [ACC_BIT-1:0]  result,
  output logic                result_vld,
  output logic                result_ovf,
  output logic [CNT_BIT-1:0]  mac_count,
  output logic                dbg_acc_state
);

  localparam int PW = 2 * DATA_BIT;
  localparam int EW = ACC_BIT + 1;

  // The accumulator is IDLE when it holds zero with no fire since reset or tile end.
  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  // Forwarding registers
  logic [DATA_BIT-1:0] south_q, east_q;
  logic                south_vld_q, east_vld_q, east_last_q;

  // S1: registered operands and fire qualifiers
  logic [DATA_BIT-1:0] n1_q, w1_q;
  logic                fire1_q, last1_q;
  logic                fire_d;

  // S2: registered product
  logic [PW-1:0]       prod_d, prod2_q;
  logic                fire2_q, last2_q;
  logic [PW-1:0]       n_ext, w_ext;

  // S3: accumulator and result
  logic [ACC_BIT-1:0]  acc_q, acc_d;
  logic                sticky_q;
  logic [CNT_BIT-1:0]  cnt_q, cnt_d;
  logic [ACC_BIT-1:0]  result_q;
  logic                result_vld_q, result_ovf_q;
  acc_state_e          state_q;
  logic [EW-1:0]       acc_ext, prod_ext, sum;
  logic                ovf;

  assign fire_d = in_north_vld & in_west_vld;

  // Forward both operand streams one hop, independent of MAC activity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      south_q     <= '0;
      south_vld_q <= 1'b0;
      east_q      <= '0;
      east_vld_q  <= 1'b0;
      east_last_q <= 1'b0;
    end else begin
      south_q     <= in_north;
      south_vld_q <= in_north_vld;
      east_q      <= in_west;
      east_vld_q  <= in_west_vld;
      east_last_q <= in_west_last;
    end
  end

  // S1: capture operands, fire, and last qualified by fire (a lone last is dropped)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n1_q    <= '0;
      w1_q    <= '0;
      fire1_q <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      n1_q    <= in_north;
      w1_q    <= in_west;
      fire1_q <= fire_d;
      last1_q <= fire_d & in_west_last;
    end
  end

  // Extend both operands to product width so the low PW bits are the exact product
  always_comb begin
    n_ext  = {{DATA_BIT{(SIGNED != 0) ? n1_q[DATA_BIT-1] : 1'b0}}, n1_q};
    w_ext  = {{DATA_BIT{(SIGNED != 0) ? w1_q[DATA_BIT-1] : 1'b0}}, w1_q};
    prod_d = n_ext * w_ext;
  end

  // S2: register the full-width product with its qualifiers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod2_q <= '0;
      fire2_q <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      prod2_q <= prod_d;
      fire2_q <= fire1_q;
      last2_q <= last1_q;
    end
  end

  // S3 datapath: one-bit-wider sum, overflow detection, then clamp or wrap
  always_comb begin
    acc_ext  = {(SIGNED != 0) ? acc_q[ACC_BIT-1] : 1'b0, acc_q};
    prod_ext = {{(EW-PW){(SIGNED != 0) ? prod2_q[PW-1] : 1'b0}}, prod2_q};
    sum      = acc_ext + prod_ext;
    if (SIGNED != 0) ovf = sum[ACC_BIT] ^ sum[ACC_BIT-1];
    else             ovf = sum[ACC_BIT];
    acc_d = sum[ACC_BIT-1:0];
    if (ovf && (SATURATE != 0)) begin
      if (SIGNED != 0) begin
        // The extra sign bit tells which way the true sum escaped the range
        acc_d = sum[ACC_BIT] ? {1'b1, {(ACC_BIT-1){1'b0}}} : {1'b0, {(ACC_BIT-1){1'b1}}};
      end else begin
        acc_d = '1;
      end
    end
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_BIT'(1);
  end

  // S3 state: accumulate on fire, publish and restart on a last fire, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      result_ovf_q <= 1'b0;
      state_q      <= ACC_IDLE;
    end else begin
      result_vld_q <= 1'b0;
      if (fire2_q) begin
        if (last2_q) begin
          result_q     <= acc_d;
          result_ovf_q <= sticky_q | ovf;
          result_vld_q <= 1'b1;
          acc_q        <= '0;
          sticky_q     <= 1'b0;
          cnt_q        <= '0;
          state_q      <= ACC_IDLE;
        end else begin
          acc_q    <= acc_d;
          sticky_q <= sticky_q | ovf;
          cnt_q    <= cnt_d;
          state_q  <= ACC_ACCUM;
        end
      end
    end
  end

  assign out_south     = south_q;
  assign out_south_vld = south_vld_q;
  assign out_east      = east_q;
  assign out_east_vld  = east_vld_q;
  assign out_east_last = east_last_q;
  assign result        = result_q;
  assign result_vld    = result_vld_q;
  assign result_ovf    = result_ovf_q;
  assign mac_count     = cnt_q;
  assign dbg_acc_state = state_q;

endmodule
